// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Holds the default 640x480@60 Hz timing constants, the derived line/frame
// totals, the sync pulse boundaries, and a small window-compare helper used
// by the timing generator.
package vga_timing_pkg;

    // Coordinate counters are 10-bit unsigned, so totals must fit in 1024.
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CNT_MAX = 1 << CNT_W;

    typedef logic [CNT_W-1:0] coord_t;

    // Default timing: 25 MHz pixel rate from a 50 MHz board clock.
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam logic        DEF_SYNC_POL = 1'b0;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    // lo <= v < hi, evaluated at 32 bits so hi may equal 1024.
    function automatic logic in_window(coord_t v, int unsigned lo, int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Pixel clock-enable divider.
// div_cnt counts 0..CLK_DIV-1 and wraps; pix_en is decoded from the
// register, so it is a clean one-clk pulse once every CLK_DIV clocks.
// With CLK_DIV=1 the counter never leaves 0 and pix_en is constantly high.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   pix_en - one-clk pulse per pixel period
module pix_clk_en
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pix_clk_en: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign pix_en = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 Hz by default).
// Produces the pixel coordinates and active-area flag consumed by the
// overlay renderers, and the hsync/vsync pins for the DAC.
// Ports:
//   clk           - system clock (50 MHz)
//   rst_n         - asynchronous active-low reset
//   pix_en        - one-clk pulse per pixel period
//   x, y          - current pixel coordinates
//   active_pixels - high inside the visible area
//   hsync, vsync  - sync outputs, asserted level SYNC_POL
//   line_tick     - one-clk pulse in the cycle after x wraps to 0
//   frame_tick    - one-clk pulse in the cycle after (x,y) becomes (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pix_en,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active_pixels,
    output logic             hsync,
    output logic             vsync,
    output logic             line_tick,
    output logic             frame_tick
);

    localparam int unsigned LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END    = HS_START + H_SYNC;
    localparam int unsigned VS_START  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END    = VS_START + V_SYNC;

    if (LINE_LEN > CNT_MAX || FRAME_LEN > CNT_MAX) begin : g_bad_timing
        $error("vga_timing_gen: line and frame totals must not exceed 1024");
    end

    localparam coord_t H_LAST = coord_t'(LINE_LEN - 1);
    localparam coord_t V_LAST = coord_t'(FRAME_LEN - 1);

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en)
    );

    coord_t h_cnt;
    coord_t v_cnt;
    coord_t h_next;
    coord_t v_next;
    logic   h_wrap;
    logic   v_wrap;

    // Next raster position; v only moves on the h wrap.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_next = h_wrap ? '0 : h_cnt + coord_t'(1);
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_cnt + coord_t'(1);
        end
    end

    // Counters start at the last position so the first pixel edge lands on
    // (0,0). Outputs are decoded from the next counter values and loaded on
    // the same edge, keeping x/y and the flags/syncs aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt         <= H_LAST;
            v_cnt         <= V_LAST;
            x             <= '0;
            y             <= '0;
            active_pixels <= 1'b0;
            hsync         <= ~SYNC_POL;
            vsync         <= ~SYNC_POL;
            line_tick     <= 1'b0;
            frame_tick    <= 1'b0;
        end else begin
            line_tick  <= pix_en && h_wrap;
            frame_tick <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                h_cnt         <= h_next;
                v_cnt         <= v_next;
                x             <= h_next;
                y             <= v_next;
                active_pixels <= in_window(h_next, 0, H_ACTIVE) &&
                                 in_window(v_next, 0, V_ACTIVE);
                hsync         <= in_window(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
                vsync         <= in_window(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations (small raster
// with CLK_DIV=2, small raster with CLK_DIV=1 and high-asserted syncs, and
// the default 640x480 timing). Each runs random-length segments separated by
// random asynchronous resets; expected pixel updates are queued at release
// and compared by a per-configuration monitor.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [31:0] cyc;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       lt;
        logic       ft;
        logic       pe;
    } obs_t;

    logic clk = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Pixel n after reset release: raster position from plain division,
    // loaded on the (n+1)*div-th clock edge.
    function automatic exp_t model(input int unsigned n, div, ha, hf, hs, hb,
                                   va, vf, vs, vb, input logic pol);
        int unsigned ht, vt, px, ln;
        exp_t e;
        ht    = ha + hf + hs + hb;
        vt    = va + vf + vs + vb;
        px    = n % ht;
        ln    = (n / ht) % vt;
        e.cyc = (n + 1) * div;
        e.x   = 10'(px);
        e.y   = 10'(ln);
        e.act = (px < ha) && (ln < va);
        e.hs  = (px >= ha + hf && px < ha + hf + hs) ? pol : ~pol;
        e.vs  = (ln >= va + vf && ln < va + vf + vs) ? pol : ~pol;
        return e;
    endfunction

    task automatic check(input int cfg, input string what, input int unsigned cyc,
                         input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s cyc=%0d got x=%0d y=%0d act=%b hs=%b vs=%b lt=%b ft=%b pe=%b required x=%0d y=%0d act=%b hs=%b vs=%b lt=%b ft=%b pe=%b",
                     cfg, what, cyc, got.x, got.y, got.act, got.hs, got.vs, got.lt, got.ft, got.pe,
                     exp.x, exp.y, exp.act, exp.hs, exp.vs, exp.lt, exp.ft, exp.pe);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int unsigned DIV = (g == 1) ? 1 : 2;
        localparam int unsigned HA  = (g == 0) ? 16 : (g == 1) ? 12 : 640;
        localparam int unsigned HF  = (g == 0) ? 4  : (g == 1) ? 3  : 16;
        localparam int unsigned HS  = (g == 0) ? 6  : (g == 1) ? 5  : 96;
        localparam int unsigned HB  = (g == 0) ? 4  : (g == 1) ? 4  : 48;
        localparam int unsigned VA  = (g == 0) ? 10 : (g == 1) ? 6  : 480;
        localparam int unsigned VF  = (g == 0) ? 2  : (g == 1) ? 1  : 10;
        localparam int unsigned VS  = 2;
        localparam int unsigned VB  = (g == 0) ? 3  : (g == 1) ? 2  : 33;
        localparam logic        POL = (g == 1);
        localparam int unsigned FIRST_LEN = (g == 0) ? 2047 : (g == 1) ? 600 : 3300;
        localparam int unsigned MAX_LEN   = (g == 0) ? 2500 : (g == 1) ? 700 : 5000;
        localparam int unsigned NSEG      = (g == 0) ? 8    : (g == 1) ? 12  : 6;

        logic       rst_n   = 1'b1;
        logic       started = 1'b0;
        logic       done    = 1'b0;
        logic       pix_en, act, hs, vs, lt, ft;
        logic [9:0] x, y;
        exp_t       q[$];

        vga_timing_gen #(
            .CLK_DIV  (DIV),
            .H_ACTIVE (HA),
            .H_FP     (HF),
            .H_SYNC   (HS),
            .H_BP     (HB),
            .V_ACTIVE (VA),
            .V_FP     (VF),
            .V_SYNC   (VS),
            .V_BP     (VB),
            .SYNC_POL (POL)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .pix_en        (pix_en),
            .x             (x),
            .y             (y),
            .active_pixels (act),
            .hsync         (hs),
            .vsync         (vs),
            .line_tick     (lt),
            .frame_tick    (ft)
        );

        // Stimulus: reset, release, queue the expected pixel updates for the
        // segment, run it, then reset asynchronously just after an edge.
        initial begin
            int unsigned len, hold;
            #2 rst_n = 1'b0;
            started = 1'b1;
            for (int s = 0; s < int'(NSEG); s++) begin
                hold = $urandom_range(1, 4);
                repeat (hold) @(negedge clk);
                #1 rst_n = 1'b1;
                if (s == 0)
                    len = FIRST_LEN;
                else if (s % 2 == 1)
                    len = $urandom_range(1, 3 * DIV + 2);
                else
                    len = $urandom_range(1, MAX_LEN);
                for (int unsigned n = 0; (n + 1) * DIV <= len; n++)
                    q.push_back(model(n, DIV, HA, HF, HS, HB, VA, VF, VS, VB, POL));
                repeat (len) @(posedge clk);
                #1 rst_n = 1'b0;
            end
            repeat (3) @(negedge clk);
            done = 1'b1;
        end

        // Monitor: pops an entry when its update cycle comes round; pix_en
        // must announce the next queued update one cycle ahead.
        initial begin
            int unsigned cyc;
            int          rd;
            logic        upd, pe_e;
            exp_t        cur;
            obs_t        got, exp;
            cyc = 0;
            rd  = 0;
            cur = {32'd0, 10'd0, 10'd0, 1'b0, ~POL, ~POL};
            wait (started);
            forever begin
                @(negedge clk);
                got = {x, y, act, hs, vs, lt, ft, pix_en};
                if (!rst_n) begin
                    cyc = 0;
                    rd  = q.size();
                    cur = {32'd0, 10'd0, 10'd0, 1'b0, ~POL, ~POL};
                    exp = {10'd0, 10'd0, 1'b0, ~POL, ~POL, 1'b0, 1'b0, (DIV == 1)};
                    check(g, "reset", cyc, got, exp);
                end else begin
                    cyc++;
                    upd = (rd < q.size()) && (q[rd].cyc == cyc);
                    if (upd) begin
                        cur = q[rd];
                        rd++;
                    end
                    pe_e = (rd < q.size()) && (q[rd].cyc == cyc + 1);
                    exp  = {cur.x, cur.y, cur.act, cur.hs, cur.vs,
                            upd && (cur.x == 10'd0),
                            upd && (cur.x == 10'd0) && (cur.y == 10'd0),
                            pe_e};
                    check(g, upd ? "pixel" : "hold", cyc, got, exp);
                end
            end
        end
    end

    initial begin
        for (int t = 0; t < 60000; t++) begin
            @(posedge clk);
            if (u[0].done && u[1].done && u[2].done) break;
        end
        if (!(u[0].done && u[1].done && u[2].done)) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: stimulus done=%b%b%b required 111",
                     u[0].done, u[1].done, u[2].done);
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
